// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and sizes for the register-file dump reader.
// Optional checksum beat selected by RF_DUMP_CHECKSUM_EN.
package rf_dump_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/rf_dump_csum.sv
// rf_dump_csum: clear/accumulate XOR register for the dump checksum.
// Only instantiated when RF_DUMP_CHECKSUM_EN is defined.
module rf_dump_csum
  import rf_dump_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  // clr restarts the sum; clr with acc loads the first word directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= acc ? din : '0;
    end else if (acc) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: sweeps the register-file read port 0..31 and streams words.
// Define RF_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module rf_dump_reader
  import rf_dump_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rf_read_addr_o,
  input  logic [DATA_W-1:0] rf_read_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic              m_last_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

`ifdef RF_DUMP_CHECKSUM_EN
  localparam bit WORD_LAST = 1'b0;
`else
  localparam bit WORD_LAST = 1'b1;
`endif

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] idx_p1;
  logic [ADDR_W-1:0] idx_p2;
  logic              hs;

  assign idx_p1 = index + 1'b1;
  assign idx_p2 = index + 2'd2;
  assign hs     = m_valid_o & m_ready_i;

`ifdef RF_DUMP_CHECKSUM_EN
  logic              at_end;
  logic              csum_clr;
  logic              csum_acc;
  logic [DATA_W-1:0] csum;

  assign at_end   = (index == LAST_IDX);
  assign csum_clr = (state == FETCH);
  assign csum_acc = csum_clr |
                    ((state == SEND) & hs &
                     ~m_last_o & ~at_end);

  rf_dump_csum #(
    .DATA_W(DATA_W)
  ) u_csum (
    .clk(clk_i),
    .rst(rst_i),
    .clr(csum_clr),
    .acc(csum_acc),
    .din(rf_read_data_i),
    .sum(csum)
  );
`endif

  // dump sequencer with registered stream, status and read-address outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      index          <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      rf_read_addr_o <= '0;
      m_valid_o      <= 1'b0;
      m_data_o       <= '0;
      m_addr_o       <= '0;
      m_last_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            index          <= '0;
            rf_read_addr_o <= '0;
            busy_o         <= 1'b1;
            state          <= FETCH;
          end
        end
        FETCH: begin
          m_data_o       <= rf_read_data_i;
          m_addr_o       <= index;
          m_last_o       <= WORD_LAST &&
                            (index == LAST_IDX);
          m_valid_o      <= 1'b1;
          rf_read_addr_o <= idx_p1;
          state          <= SEND;
        end
        SEND: begin
          if (hs) begin
            if (m_last_o) begin
              m_valid_o <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              state     <= DONE;
            end
`ifdef RF_DUMP_CHECKSUM_EN
            else if (at_end) begin
              m_data_o <= csum;
              m_addr_o <= '1;
              m_last_o <= 1'b1;
            end
`endif
            else begin
              m_data_o       <= rf_read_data_i;
              m_addr_o       <= idx_p1;
              m_last_o       <= WORD_LAST &&
                                (idx_p1 == LAST_IDX);
              index          <= idx_p1;
              rf_read_addr_o <= idx_p2;
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader: table-driven and randomized checks of the dump reader
// against a register-file model and a snapshot-based beat model.
module tb_rf_dump_reader;
  import rf_dump_pkg::*;

  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;
  localparam int NR = RF_NUM_REGS;
`ifdef RF_DUMP_CHECKSUM_EN
  localparam int NB = NR + 1;
  localparam bit CS = 1'b1;
`else
  localparam int NB = NR;
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic          m_last;

  logic [DW-1:0] regs [NR];

  // register file model: combinational read, x0 reads as zero
  assign rf_data = (rf_addr == '0) ? '0 : regs[rf_addr];

  rf_dump_reader dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .busy_o(busy),
    .done_o(done),
    .rf_read_addr_o(rf_addr),
    .rf_read_data_i(rf_data),
    .m_valid_o(m_valid),
    .m_ready_i(ready),
    .m_data_o(m_data),
    .m_addr_o(m_addr),
    .m_last_o(m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t got[$];
  beat_t exp_q[$];

  typedef struct {
    string         name;
    int            pre;
    int            mode;
    bit            extra;
    int            wreg;
    logic [DW-1:0] wval;
    bit            chk_lat;
    int            sp_beat;
    logic [AW-1:0] sp_addr;
    logic [DW-1:0] sp_data;
    logic          sp_last;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, want);
    end
  endtask

  task automatic preload(input int pre);
    for (int k = 0; k < NR; k++) begin
      if (pre == 0)      regs[k] = 32'hA500_0000 | k;
      else if (pre == 1) regs[k] = k;
      else               regs[k] = $urandom;
    end
  endtask

  // expected dump: each word as the register file holds it when captured;
  // a write issued while beat wbeat is on the bus only reaches later words
  task automatic build_exp(input int wreg, input int wbeat,
                           input logic [DW-1:0] wval);
    logic [DW-1:0] x;
    logic [DW-1:0] v;
    x = '0;
    exp_q.delete();
    for (int k = 0; k < NR; k++) begin
      v = regs[k];
      if (k == wreg && k > wbeat) v = wval;
      if (k == 0) v = '0;
      x ^= v;
      exp_q.push_back('{AW'(k), v, !CS && k == NR - 1});
    end
    if (CS) exp_q.push_back('{'1, x, 1'b1});
  endtask

  function automatic logic ready_of(input int mode, input int s);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (s % 3) == 0;
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic run(input string nm, input int mode,
                     input bit extra, input int wreg,
                     input logic [DW-1:0] wval,
                     input bit chk_lat);
    int    c0, dcyc, dcnt, s, n_cmp;
    bit    p3, p20, wdone, pstall;
    beat_t prev;
    c0 = 0; dcyc = 0; dcnt = 0; s = 0;
    p3 = 0; p20 = 0; wdone = 0; pstall = 0;
    prev = '{'0, '0, 1'b0};
    got.delete();
    build_exp(wreg, 5, wval);
    @(posedge clk); #1;
    start = 1'b1;
    ready = ready_of(mode, s++);
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b0;
    ready = ready_of(mode, s++);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (pstall)
        check({nm, "_stall"},
              {25'd0, m_valid, m_last, m_addr, m_data},
              {25'd0, 1'b1, prev.l, prev.a, prev.d});
      pstall = m_valid && !ready;
      prev = '{m_addr, m_data, m_last};
      if (m_valid && ready)
        got.push_back('{m_addr, m_data, m_last});
      if (done) begin
        dcnt++;
        if (dcnt == 1) dcyc = cyc;
      end
      if (dcnt > 0 && cyc > dcyc + 3) break;
      @(posedge clk); #1;
      ready = ready_of(mode, s++);
      start = 1'b0;
      if (extra && !p3 && got.size() == 3) begin
        start = 1'b1; p3 = 1;
      end
      if (extra && !p20 && got.size() == 20) begin
        start = 1'b1; p20 = 1;
      end
      if (wreg >= 0 && !wdone && got.size() == 5 && m_valid) begin
        regs[wreg] = wval;
        wdone = 1;
      end
    end
    start = 1'b0;
    check({nm, "_done_cnt"}, 64'(dcnt), 64'd1);
    check({nm, "_busy_end"}, {63'd0, busy}, 64'd0);
    check({nm, "_nbeats"}, 64'(got.size()), 64'(exp_q.size()));
    n_cmp = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++)
      check($sformatf("%s_beat%0d", nm, i),
            {25'd0, got[i].l, got[i].a, got[i].d},
            {25'd0, exp_q[i].l, exp_q[i].a, exp_q[i].d});
    if (chk_lat)
      check({nm, "_latency"}, 64'(dcyc - c0), 64'(NB + 1));
  endtask

  initial begin
    int hs;
    // rows: name, preload, ready mode, extra starts, write reg/value,
    // latency check, then one hand-derived beat to spot check
    vecs.push_back('{"ready_hi", 0, 0, 0, -1, '0, 1,
                     31, 5'd31, 32'hA500_001F, !CS});
    vecs.push_back('{"ready_tog", 0, 1, 0, -1, '0, 0,
                     0, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{"restart_ign", 0, 0, 1, -1, '0, 1,
                     20, 5'd20, 32'hA500_0014, 1'b0});
    vecs.push_back('{"wr_r31", 0, 0, 0, 31, 32'h1234, 1,
                     31, 5'd31, 32'h1234, !CS});
    vecs.push_back('{"wr_r2", 0, 1, 0, 2, 32'hFFFF, 0,
                     2, 5'd2, 32'hA500_0002, 1'b0});
`ifdef RF_DUMP_CHECKSUM_EN
    vecs.push_back('{"seq_k", 1, 2, 0, -1, '0, 0,
                     32, 5'h1F, 32'h0, 1'b1});
`else
    vecs.push_back('{"seq_k", 1, 2, 0, -1, '0, 0,
                     31, 5'h1F, 32'h1F, 1'b1});
`endif

    preload(0);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, m_valid}, 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_addr", 64'(m_addr), 64'd0);
    check("rst_last", {63'd0, m_last}, 64'd0);
    check("rst_rfaddr", 64'(rf_addr), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (vecs[i]) begin
      preload(vecs[i].pre);
      run(vecs[i].name, vecs[i].mode, vecs[i].extra,
          vecs[i].wreg, vecs[i].wval, vecs[i].chk_lat);
      if (vecs[i].sp_beat < got.size())
        check({vecs[i].name, "_spot"},
              {25'd0, got[vecs[i].sp_beat].l,
               got[vecs[i].sp_beat].a, got[vecs[i].sp_beat].d},
              {25'd0, vecs[i].sp_last,
               vecs[i].sp_addr, vecs[i].sp_data});
      else
        check({vecs[i].name, "_spot_missing"},
              64'(got.size()), 64'(vecs[i].sp_beat + 1));
    end

    // asynchronous reset while beat 10 is on the bus
    preload(0);
    hs = 0;
    @(posedge clk); #1;
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_valid && ready) hs++;
      @(posedge clk); #1;
      if (hs == 10) break;
    end
    check("mid_pre_valid", {63'd0, m_valid}, 64'd1);
    check("mid_pre_addr", 64'(m_addr), 64'd10);
    #2 rst = 1'b1;
    #1;
    check("mid_valid", {63'd0, m_valid}, 64'd0);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    hs = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done || m_valid || busy) hs++;
    end
    check("mid_quiet", 64'(hs), 64'd0);
    run("after_rst", 0, 0, -1, '0, 1);

    // randomized contents, back-pressure and late writes
    for (int r = 0; r < 4; r++) begin
      preload(2);
      run($sformatf("rand%0d", r), 2, r[0],
          (r < 2) ? -1 : int'($urandom_range(NR - 1, 1)),
          $urandom, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
